// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style main controller for a multicycle RISC-V datapath.
//               Sequences fetch / decode / execute / memory / writeback,
//               drives datapath selects and write enables, decodes ALU
//               control and immediate format, and traps on illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_HANDSHAKE = 1,  // 1: memory states wait for mem_ready
    parameter int EXT_BRANCH    = 1,  // 1: BNE/BLT/BGE in addition to BEQ
    parameter int TRAP_EN       = 1   // 1: illegal opcode parks in TRAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       trap,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_JAL      = 4'd8;
    localparam logic [3:0] c_ALUWB    = 4'd9;
    localparam logic [3:0] c_BRANCH   = 4'd10;
    localparam logic [3:0] c_TRAP     = 4'd11;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;
    logic       w_taken;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;

    // With the handshake disabled every memory access completes in one cycle
    assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State register; reset aborts any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:    w_next = w_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = c_MEMADR;
                    c_OP_RTYPE:            w_next = c_EXECUTER;
                    c_OP_ITYPE:            w_next = c_EXECUTEI;
                    c_OP_JAL:              w_next = c_JAL;
                    c_OP_BRANCH:           w_next = c_BRANCH;
                    default:               w_next = (TRAP_EN != 0) ? c_TRAP : c_FETCH;
                endcase
            end
            c_MEMADR:   w_next = op[5] ? c_MEMWRITE : c_MEMREAD;
            c_MEMREAD:  w_next = w_ready ? c_MEMWB : c_MEMREAD;
            c_MEMWB:    w_next = c_FETCH;
            c_MEMWRITE: w_next = w_ready ? c_FETCH : c_MEMWRITE;
            c_EXECUTER: w_next = c_ALUWB;
            c_EXECUTEI: w_next = c_ALUWB;
            c_JAL:      w_next = c_ALUWB;
            c_ALUWB:    w_next = c_FETCH;
            c_BRANCH:   w_next = c_FETCH;
            c_TRAP:     w_next = c_TRAP;
            default:    w_next = c_FETCH;
        endcase
    end

    // Branch condition; extended compares collapse to not-taken when disabled
    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = (EXT_BRANCH != 0) && !Zero;
            3'b100:  w_taken = (EXT_BRANCH != 0) && lt;
            3'b101:  w_taken = (EXT_BRANCH != 0) && !lt;
            default: w_taken = 1'b0;
        endcase
    end

    // Per-state datapath controls; anything not named in a state stays 0
    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = 2'b00;
        trap        = 1'b0;
        case (r_state)
            c_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_ir_write = w_ready;
                w_pc_write = w_ready;
            end
            c_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            c_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            c_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            c_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            c_MEMWRITE: begin
                // Write strobe is held for the whole wait, not just the last cycle
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            c_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            c_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            c_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pc_write = 1'b1;
            end
            c_ALUWB: begin
                w_reg_write = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcA    = 2'b10;
                w_alu_op   = 2'b01;
                w_pc_write = w_taken;
            end
            c_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

    // ALU operation decode; op[5] separates R-type SUB from I-type ADDI
    always_comb begin
        ALUControl = 3'b111;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b111;
                endcase
            end
            default: ALUControl = 3'b111;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            c_OP_STORE:  ImmSrc = 2'b01;
            c_OP_BRANCH: ImmSrc = 2'b10;
            c_OP_JAL:    ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed for as long as reset is held
    assign PCWrite  = w_pc_write  & rst_n;
    assign IRWrite  = w_ir_write  & rst_n;
    assign MemWrite = w_mem_write & rst_n;
    assign RegWrite = w_reg_write & rst_n;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control. Expected per-cycle
//               output vectors are queued with their stimulus, then popped and
//               compared cycle by cycle. A second instance built with
//               EXT_BRANCH=0 / TRAP_EN=0 is tracked on state, PCWrite, trap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       lt;
    logic       mem_ready;

    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    logic       PCWrite2, IRWrite2, MemWrite2, RegWrite2, AdrSrc2, trap2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [2:0] ALUControl2;
    logic [3:0] state2;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .lt(lt), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .trap(trap), .state(state)
    );

    multicycle_control #(.MEM_HANDSHAKE(1), .EXT_BRANCH(0), .TRAP_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .lt(lt), .mem_ready(mem_ready),
        .PCWrite(PCWrite2), .IRWrite(IRWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
        .AdrSrc(AdrSrc2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .trap(trap2), .state(state2)
    );

    always #5 clk = ~clk;

    // {state, PCW, IRW, MW, RW, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap}
    logic [20:0] got;
    assign got = {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap};
    logic [5:0] got2;
    assign got2 = {state2, PCWrite2, trap2};

    int n_checks = 0;
    int n_errors = 0;

    bit          mr_q[$];
    logic [20:0] exp_q[$];
    logic [5:0]  exp2_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Expected output vector for a state; f is mem_ready in FETCH, taken in BRANCH
    function automatic logic [20:0] ev(input int st, input logic [1:0] imm, input bit f,
                                       input logic [2:0] alc);
        //          st     pcw   irw   mw    rw    adr   rs     sa     sb     imm  alc  trap
        case (st)
            0:  ev = {4'd0,  f,    f,    1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0};
            1:  ev = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0};
            2:  ev = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0};
            3:  ev = {4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
            4:  ev = {4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0};
            5:  ev = {4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
            6:  ev = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, alc,    1'b0};
            7:  ev = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, alc,    1'b0};
            8:  ev = {4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 1'b0};
            9:  ev = {4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0};
            10: ev = {4'd10, f,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 1'b0};
            default: ev = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1};
        endcase
    endfunction

    task automatic push2(input string tag, input bit mr, input logic [20:0] e, input logic [5:0] e2);
        tag_q.push_back(tag);
        mr_q.push_back(mr);
        exp_q.push_back(e);
        exp2_q.push_back(e2);
    endtask

    // Second instance is expected to match the first on state, PCWrite and trap
    task automatic push(input string tag, input bit mr, input logic [20:0] e);
        push2(tag, mr, e, {e[20:17], e[16], e[0]});
    endtask

    // Drive queued stimulus one cycle at a time and compare against the queue
    task automatic run_q();
        string t;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            mem_ready = mr_q.pop_front();
            #1;
            check(t, 32'(got), 32'(exp_q.pop_front()));
            check({t, "/nx"}, 32'(got2), 32'(exp2_q.pop_front()));
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // R-type funct3/funct7b5 cases and the ALUControl each must produce
    logic [2:0] r_f3[6]  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b001};
    logic       r_f7[6]  = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    logic [2:0] r_alc[6] = '{3'b001, 3'b101, 3'b100, 3'b011, 3'b010, 3'b111};

    // Branch cases: funct3, Zero, lt, taken (full), taken (BEQ-only)
    logic [2:0] b_f3[8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b101, 3'b010};
    bit         b_z[8]  = '{0, 1, 1, 0, 0, 0, 0, 1};
    bit         b_lt[8] = '{0, 0, 0, 0, 1, 1, 0, 1};
    bit         b_t1[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit         b_t2[8] = '{0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; lt = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        @(negedge clk);
        #1;
        check("reset", 32'(got), 32'(ev(0, 2'b00, 1'b0, 3'b000)));
        check("reset/nx", 32'(got2), 32'({4'd0, 1'b0, 1'b0}));
        rst_n = 1'b1;

        // add: FETCH, DECODE, EXECUTER, ALUWB
        push("add.f", 1, ev(0, 2'b00, 1, 0));
        push("add.d", 1, ev(1, 2'b00, 0, 0));
        push("add.x", 1, ev(6, 2'b00, 0, 3'b000));
        push("add.wb", 1, ev(9, 2'b00, 0, 0));
        run_q();

        // R-type ALU decode sweep
        for (int i = 0; i < 6; i++) begin
            set_instr(7'b0110011, r_f3[i], r_f7[i]);
            push($sformatf("r%0d.f", i), 1, ev(0, 2'b00, 1, 0));
            push($sformatf("r%0d.d", i), 1, ev(1, 2'b00, 0, 0));
            push($sformatf("r%0d.x", i), 1, ev(6, 2'b00, 0, r_alc[i]));
            push($sformatf("r%0d.wb", i), 1, ev(9, 2'b00, 0, 0));
            run_q();
        end

        // addi with funct7b5=1 must still add; ori decodes to OR
        set_instr(7'b0010011, 3'b000, 1'b1);
        push("addi.f", 1, ev(0, 2'b00, 1, 0));
        push("addi.d", 1, ev(1, 2'b00, 0, 0));
        push("addi.x", 1, ev(7, 2'b00, 0, 3'b000));
        push("addi.wb", 1, ev(9, 2'b00, 0, 0));
        run_q();
        set_instr(7'b0010011, 3'b110, 1'b0);
        push("ori.f", 1, ev(0, 2'b00, 1, 0));
        push("ori.d", 1, ev(1, 2'b00, 0, 0));
        push("ori.x", 1, ev(7, 2'b00, 0, 3'b011));
        push("ori.wb", 1, ev(9, 2'b00, 0, 0));
        run_q();

        // lw with one stalled fetch cycle and one stalled read cycle
        set_instr(7'b0000011, 3'b010, 1'b0);
        push("lw.f0", 0, ev(0, 2'b00, 0, 0));
        push("lw.f", 1, ev(0, 2'b00, 1, 0));
        push("lw.d", 1, ev(1, 2'b00, 0, 0));
        push("lw.ma", 1, ev(2, 2'b00, 0, 0));
        push("lw.rd0", 0, ev(3, 2'b00, 0, 0));
        push("lw.rd", 1, ev(3, 2'b00, 0, 0));
        push("lw.wb", 1, ev(4, 2'b00, 0, 0));
        run_q();
        // lw without stalls: 5 cycles
        push("lw2.f", 1, ev(0, 2'b00, 1, 0));
        push("lw2.d", 1, ev(1, 2'b00, 0, 0));
        push("lw2.ma", 1, ev(2, 2'b00, 0, 0));
        push("lw2.rd", 1, ev(3, 2'b00, 0, 0));
        push("lw2.wb", 1, ev(4, 2'b00, 0, 0));
        run_q();

        // sw held in MEMWRITE for 3 not-ready cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        push("sw.f", 1, ev(0, 2'b01, 1, 0));
        push("sw.d", 1, ev(1, 2'b01, 0, 0));
        push("sw.ma", 1, ev(2, 2'b01, 0, 0));
        for (int i = 0; i < 3; i++) push($sformatf("sw.w%0d", i), 0, ev(5, 2'b01, 0, 0));
        push("sw.w", 1, ev(5, 2'b01, 0, 0));
        run_q();

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        push("jal.f", 1, ev(0, 2'b11, 1, 0));
        push("jal.d", 1, ev(1, 2'b11, 0, 0));
        push("jal.j", 1, ev(8, 2'b11, 0, 0));
        push("jal.wb", 1, ev(9, 2'b11, 0, 0));
        run_q();

        // branches; BEQ-only instance expects its own taken value
        for (int i = 0; i < 8; i++) begin
            set_instr(7'b1100011, b_f3[i], 1'b0);
            Zero = b_z[i]; lt = b_lt[i];
            push($sformatf("br%0d.f", i), 1, ev(0, 2'b10, 1, 0));
            push($sformatf("br%0d.d", i), 1, ev(1, 2'b10, 0, 0));
            push2($sformatf("br%0d.b", i), 1, ev(10, 2'b10, b_t1[i], 0),
                  {4'd10, b_t2[i], 1'b0});
            run_q();
        end
        Zero = 1'b0; lt = 1'b0;

        // illegal opcode: TRAP for 10 cycles; non-trapping instance keeps cycling
        set_instr(7'b1111111, 3'b000, 1'b0);
        push("ill.f", 1, ev(0, 2'b00, 1, 0));
        push("ill.d", 1, ev(1, 2'b00, 0, 0));
        for (int i = 0; i < 10; i++)
            push2($sformatf("trap%0d", i), 1, ev(11, 2'b00, 0, 0),
                  (i % 2 == 0) ? {4'd0, 1'b1, 1'b0} : {4'd1, 1'b0, 1'b0});
        run_q();
        rst_n = 1'b0;
        #1;
        check("trap.rst", 32'(got), 32'(ev(0, 2'b00, 0, 0)));
        check("trap.rst/nx", 32'(got2), 32'({4'd0, 1'b0, 1'b0}));
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // reset during a MEMWRITE wait, then a clean fetch
        set_instr(7'b0100011, 3'b010, 1'b0);
        push("swr.f", 1, ev(0, 2'b01, 1, 0));
        push("swr.d", 1, ev(1, 2'b01, 0, 0));
        push("swr.ma", 1, ev(2, 2'b01, 0, 0));
        push("swr.w", 0, ev(5, 2'b01, 0, 0));
        run_q();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("swr.rst", 32'(got), 32'(ev(0, 2'b01, 0, 0)));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0);
        push("post.f", 1, ev(0, 2'b00, 1, 0));
        push("post.d", 1, ev(1, 2'b00, 0, 0));
        run_q();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
